clk_div_switch: RTL
===================

# clk_div_switch

Parametrised glitch-free clock divider with run-time ratio switching, generating a divided clock from one source clock. A ratio change is a request/acknowledge handshake: the old ratio always finishes its current period, the output is held low for a programmable dead time, then the new ratio starts on a clean rising edge. It sits alongside the clock muxes in the clock-generation area and drives peripheral clocks whose frequency is changed by software.

## Interface
- DIV_W, 8: width of divide-ratio fields; maximum ratio 2^DIV_W-1.
- GAP, 2: dead-time i_clk cycles with o_clk held low between old and new ratio (0 allowed).
- RST_DIV, 0: ratio active out of reset; 0 = output parked low.
- i_clk  in  1  source clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_div  in  DIV_W  requested ratio; sampled with i_req.
- i_req  in  1  ratio change request; single-cycle pulse or level, only sampled while o_busy=0.
- o_ack  out  1  one-cycle pulse on the edge that loads the new ratio.
- o_busy  out  1  change in progress; requests ignored.
- o_div_cur  out  DIV_W  ratio currently in effect (after clamping).
- o_clk  out  1  divided clock, directly from a flop.
- o_clk_en  out  1  one i_clk cycle high coincident with each o_clk high phase start.

## Operation
- Ratio N: 0 = parked (o_clk=0); 1 is clamped to 2 on capture, so o_div_cur reads 2; 2..2^DIV_W-1 = divide by N.
- Period of N i_clk cycles: high for H=ceil(N/2) cycles, then low for floor(N/2). A period always ends low.
- Internal phase counter cnt runs 0..N-1, wraps to 0. o_clk register is loaded with (next cnt < H), so o_clk is 1 while cnt<H.
- States: OFF (N=0), RUN, DRAIN, GAP.
- OFF: o_clk=0. i_req -> capture pend=clamp(i_div), o_busy=1, enter GAP with gap counter = GAP (so GAP+1 low cycles before load).
- RUN: i_req -> capture pend, o_busy=1, enter DRAIN. The request edge is still a normal RUN update.
- DRAIN: keep counting with old N. On the edge where cnt==N-1: if GAP==0, load immediately; else enter GAP with gap counter = GAP-1.
- GAP: o_clk=0, cnt held. Each edge decrements the gap counter; on the edge where it is 0, load.
- Load edge: o_div_cur<=pend, cnt<=0, o_ack<=1, o_busy<=0. If pend!=0: o_clk<=1, o_clk_en<=1, state RUN; else o_clk stays 0, state OFF.
- A request with the same ratio as current runs the full drain/gap/load sequence.
- i_req while o_busy=1 is ignored; no queuing.
- i_div is not observed outside the capture edge.

## Timing
- Reset values: o_clk=0, o_clk_en=0, o_ack=0, o_busy=0, o_div_cur=RST_DIV (clamped), cnt=0, state RUN if RST_DIV!=0 else OFF.
- With RST_DIV!=0, the first rising o_clk occurs on the first i_clk edge after i_rstn deasserts.
- Glitch-free by construction: o_clk changes only on i_clk rising edges. High phases are never shorter than ceil(N/2) of the ratio that started them. Low time at a switch is at least floor(N_old/2)+GAP cycles.
- GAP==0 in RUN: the new period starts on the edge immediately after the old period's last cycle; no extra low time.
- Switch latency in RUN: the edge sampling i_req, plus the cycles remaining to complete the period, plus GAP.
- Async reset mid-operation (any state): all outputs return to reset values at once; the pending request is discarded and no o_ack is issued.
- o_ack and the first high cycle of the new ratio coincide.

## Test plan
- Reset with RST_DIV=0, GAP=2; pulse i_req, i_div=4 -> o_clk low 3 cycles; o_ack with o_clk rising; then 2 high/2 low repeating; o_div_cur=4.
- RUN at N=4, request i_div=7 during a high phase -> current period completes (ends low), 2 extra low cycles, o_ack, then 4 high/3 low.
- GAP=0, switch N=6 -> N=3 -> 3 low cycles of N=6, then immediately 2 high/1 low, with no gap.
- While o_busy=1, pulse i_req with i_div=9 -> ignored; o_div_cur never 9; exactly one o_ack.
- Request i_div=1 -> o_div_cur=2, then 1 high/1 low. Request i_div=0 -> period completes, GAP, o_ack, o_clk stays 0, state OFF.
- Assert i_rstn low mid-GAP with RST_DIV=5 -> o_clk=0, o_busy=0, o_div_cur=5 immediately; after release, 3 high/2 low.

Source files
------------

// File: rtl/clk_div_switch.sv
// Glitch-free divided clock with run-time ratio switching.
// A ratio change takes effect after the current period ends plus GAP i_clk cycles of low time.
// Requests are accepted only while o_busy=0. Requests made while busy are dropped, not queued.
//
// Ports:
//   i_clk, i_rstn      source clock, async active-low reset
//   i_div, i_req       requested ratio, sampled on the i_req edge while idle
//   o_ack, o_busy      load pulse / change in progress
//   o_div_cur          ratio in effect (1 reads back as 2)
//   o_clk, o_clk_en    divided clock (flop output), strobe on each high-phase start
module clk_div_switch #(
  parameter int DIV_W   = 8,
  parameter int GAP     = 2,
  parameter int RST_DIV = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_req,
  output logic             o_ack,
  output logic             o_busy,
  output logic [DIV_W-1:0] o_div_cur,
  output logic             o_clk,
  output logic             o_clk_en
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN, S_GAP} state_t;

  localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [DIV_W-1:0] RST_CLAMP = (RST_DIV == 1) ? DIV_W'(2) : DIV_W'(RST_DIV);
  localparam state_t RST_STATE = (RST_DIV != 0) ? S_RUN : S_OFF;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == DIV_W'(1)) ? DIV_W'(2) : d;
  endfunction

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt, cnt_run;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic [DIV_W-1:0] pend;
  logic [DIV_W:0]   half;
  logic             run_start;
  logic             wrap, run_hi;
  logic             cap, load;
  logic             clk_nxt, en_nxt, ack_nxt;

  // High phase length: ceil(N/2), one bit wider so N=2^DIV_W-1 does not overflow.
  assign half = ({1'b0, o_div_cur} + (DIV_W + 1)'(1)) >> 1;
  assign wrap = (cnt == o_div_cur - DIV_W'(1));
  // Out of reset o_clk is low with cnt=0, so the first edge starts a full
  // period at cnt=0 instead of advancing to cnt=1 (which would shorten it).
  assign cnt_run = (run_start || wrap) ? '0 : cnt + DIV_W'(1);
  assign run_hi  = ({1'b0, cnt_run} < half);

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= RST_STATE;
    else         state <= state_nxt;
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    cap       = 1'b0;
    load      = 1'b0;
    unique case (state)
      S_OFF: begin
        if (i_req) begin
          cap       = 1'b1;
          state_nxt = S_GAP;
          gcnt_nxt  = GW'(GAP);
        end
      end
      S_RUN: begin
        cnt_nxt = cnt_run;
        if (i_req) begin
          cap       = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt_run;
        if (wrap) begin
          if (GAP == 0) begin
            load = 1'b1;
          end else begin
            state_nxt = S_GAP;
            gcnt_nxt  = GW'(GAP_M1);
          end
        end
      end
      S_GAP: begin
        if (gcnt == '0) load = 1'b1;
        else            gcnt_nxt = gcnt - GW'(1);
      end
    endcase
    if (load) begin
      cnt_nxt   = '0;
      state_nxt = (pend != '0) ? S_RUN : S_OFF;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    clk_nxt = 1'b0;
    en_nxt  = 1'b0;
    ack_nxt = 1'b0;
    if (load) begin
      ack_nxt = 1'b1;
      clk_nxt = (pend != '0);
      en_nxt  = (pend != '0);
    end else if (state_nxt == S_RUN || state_nxt == S_DRAIN) begin
      clk_nxt = run_hi;
      en_nxt  = (cnt_run == '0);
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt       <= '0;
      gcnt      <= '0;
      pend      <= '0;
      run_start <= 1'b1;
      o_div_cur <= RST_CLAMP;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_clk     <= 1'b0;
      o_clk_en  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      gcnt      <= gcnt_nxt;
      run_start <= 1'b0;
      o_ack     <= ack_nxt;
      o_clk     <= clk_nxt;
      o_clk_en  <= en_nxt;
      if (cap) begin
        pend   <= clamp_div(i_div);
        o_busy <= 1'b1;
      end
      if (load) begin
        o_div_cur <= pend;
        o_busy    <= 1'b0;
      end
    end
  end

endmodule
